// File: rtl/stack_calc_core.sv
// rtl/stack_calc_core.sv - parametrised stack calculator core with valid/ready opcode intake
module stack_calc_core #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [3:0]         op_code,
  input  logic [WIDTH-1:0]   op_arg,
  output logic [WIDTH-1:0]   top,
  output logic [WIDTH-1:0]   second,
  output logic [CNT_W-1:0]   depth,
  output logic [2*WIDTH-1:0] out_reg,
  output logic               carry,
  output logic               overflow,
  output logic               underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [3:0] OP_PUSH = 4'h1, OP_POP = 4'h2, OP_OUTL = 4'h3, OP_OUTH = 4'h4;
  localparam logic [3:0] OP_SWAP = 4'h5, OP_DUP = 4'h6, OP_OVER = 4'h7, OP_ADD = 4'h8;
  localparam logic [3:0] OP_ADDC = 4'h9, OP_SUB = 4'hA, OP_AND = 4'hB, OP_OR = 4'hC;
  localparam logic [3:0] OP_XOR = 4'hD, OP_MULT = 4'hE, OP_CLFL = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_PUSH_HI} state_t;

  state_t              state_q, state_d;
  logic                op_ready_q, op_ready_d;
  logic [CNT_W-1:0]    depth_q, depth_d;
  logic [2*WIDTH-1:0]  out_q, out_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [3:0]          opc_q, opc_d;
  logic [WIDTH-1:0]    arg_q, arg_d;
  logic [WIDTH-1:0]    hi_q, hi_d;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [IDX_W-1:0]    idx_push, idx_top, idx_sec;
  logic [WIDTH-1:0]    top_raw, sec_raw;
  logic [WIDTH:0]      sum_w, diff_w;
  logic [2*WIDTH-1:0]  prod_w;
  logic [CNT_W-1:0]    need;
  logic                grow;
  logic                wr0_en, wr1_en;
  logic [IDX_W-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0]    wr0_data, wr1_data;

  // Depth never exceeds 2^IDX_W, so modular index arithmetic yields sp-1 / sp-2 directly.
  assign idx_push = depth_q[IDX_W-1:0];
  assign idx_top  = depth_q[IDX_W-1:0] - IDX_W'(1);
  assign idx_sec  = depth_q[IDX_W-1:0] - IDX_W'(2);
  assign top_raw  = mem[idx_top];
  assign sec_raw  = mem[idx_sec];

  assign sum_w  = {1'b0, sec_raw} + {1'b0, top_raw} + {{WIDTH{1'b0}}, (opc_q == OP_ADDC) & carry_q};
  assign diff_w = {1'b0, sec_raw} - {1'b0, top_raw};
  assign prod_w = {{WIDTH{1'b0}}, sec_raw} * {{WIDTH{1'b0}}, top_raw};

  assign op_ready  = op_ready_q;
  assign depth     = depth_q;
  assign out_reg   = out_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign top       = (depth_q != '0) ? top_raw : '0;
  assign second    = (depth_q >= CNT_W'(2)) ? sec_raw : '0;

  // Operand requirement and whether the opcode grows the stack, for the pre-write error checks.
  always_comb begin
    need = '0;
    grow = 1'b0;
    case (opc_q)
      OP_PUSH:                   grow = 1'b1;
      OP_POP, OP_OUTL, OP_OUTH:  need = CNT_W'(1);
      OP_DUP:  begin need = CNT_W'(1); grow = 1'b1; end
      OP_OVER: begin need = CNT_W'(2); grow = 1'b1; end
      OP_SWAP, OP_ADD, OP_ADDC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MULT: need = CNT_W'(2);
      default: need = '0;
    endcase
  end

  // Next-state, datapath and stack-write selection for the accept/execute/push-high sequence.
  always_comb begin
    state_d    = state_q;
    op_ready_d = op_ready_q;
    depth_d    = depth_q;
    out_d      = out_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    opc_d      = opc_q;
    arg_d      = arg_q;
    hi_d       = hi_q;
    wr0_en     = 1'b0;
    wr0_idx    = idx_push;
    wr0_data   = '0;
    wr1_en     = 1'b0;
    wr1_idx    = idx_sec;
    wr1_data   = '0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          opc_d      = op_code;
          arg_d      = op_arg;
          state_d    = S_EXEC;
          op_ready_d = 1'b0;
        end
      end
      S_EXEC: begin
        state_d    = S_IDLE;
        op_ready_d = 1'b1;
        if (depth_q < need) begin
          unf_d = 1'b1;
        end else if (grow && depth_q == DEPTH_C) begin
          ovf_d = 1'b1;
        end else begin
          case (opc_q)
            OP_PUSH: begin wr0_en = 1'b1; wr0_data = arg_q; depth_d = depth_q + CNT_W'(1); end
            OP_POP:  depth_d = depth_q - CNT_W'(1);
            OP_OUTL: out_d[WIDTH-1:0] = top_raw;
            OP_OUTH: out_d[2*WIDTH-1:WIDTH] = top_raw;
            OP_SWAP: begin
              wr0_en = 1'b1; wr0_idx = idx_top; wr0_data = sec_raw;
              wr1_en = 1'b1; wr1_idx = idx_sec; wr1_data = top_raw;
            end
            OP_DUP:  begin wr0_en = 1'b1; wr0_data = top_raw; depth_d = depth_q + CNT_W'(1); end
            OP_OVER: begin wr0_en = 1'b1; wr0_data = sec_raw; depth_d = depth_q + CNT_W'(1); end
            OP_ADD, OP_ADDC: begin
              wr0_en = 1'b1; wr0_idx = idx_sec; wr0_data = sum_w[WIDTH-1:0];
              carry_d = sum_w[WIDTH]; depth_d = depth_q - CNT_W'(1);
            end
            OP_SUB: begin
              wr0_en = 1'b1; wr0_idx = idx_sec; wr0_data = diff_w[WIDTH-1:0];
              carry_d = diff_w[WIDTH]; depth_d = depth_q - CNT_W'(1);
            end
            OP_AND, OP_OR, OP_XOR: begin
              wr0_en = 1'b1; wr0_idx = idx_sec; depth_d = depth_q - CNT_W'(1);
              wr0_data = (opc_q == OP_AND) ? (sec_raw & top_raw) :
                         (opc_q == OP_OR)  ? (sec_raw | top_raw) : (sec_raw ^ top_raw);
            end
            OP_MULT: begin
              wr0_en = 1'b1; wr0_idx = idx_sec; wr0_data = prod_w[WIDTH-1:0];
              hi_d = prod_w[2*WIDTH-1:WIDTH]; depth_d = depth_q - CNT_W'(1);
              state_d = S_PUSH_HI; op_ready_d = 1'b0;
            end
            OP_CLFL: begin carry_d = 1'b0; ovf_d = 1'b0; unf_d = 1'b0; end
            default: ;
          endcase
        end
      end
      S_PUSH_HI: begin
        wr0_en     = 1'b1;
        wr0_data   = hi_q;
        depth_d    = depth_q + CNT_W'(1);
        state_d    = S_IDLE;
        op_ready_d = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        op_ready_d = 1'b1;
      end
    endcase
  end

  // Control, flag and latch registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_ready_q <= 1'b1;
      depth_q    <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      opc_q      <= '0;
      arg_q      <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_ready_q <= op_ready_d;
      depth_q    <= depth_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      opc_q      <= opc_d;
      arg_q      <= arg_d;
      hi_q       <= hi_d;
    end
  end

  // Stack array: no reset, contents beyond depth are masked; two ports for SWAP.
  always_ff @(posedge clk) begin
    if (!rst && wr0_en) mem[wr0_idx] <= wr0_data;
    if (!rst && wr1_en) mem[wr1_idx] <= wr1_data;
  end

endmodule

// File: doc/stack_calc_core.md
Name: stack_calc_core

Overview:
- Parametrised successor of the 4-bit stack calculator: configurable data width and stack depth.
- Stack is an addressed array with a pointer, not a shift register.
- Opcodes arrive through a valid/ready handshake instead of a fetch cycle.
- Adds depth tracking, sticky overflow/underflow detection, SUB/OVER/DUP opcodes and a 2*WIDTH output latch.
- Sits between the pin-level io wrapper (opcode/operand source, output mux) and the seven-segment/output multiplexers.

Parameters:
WIDTH, 8, data word width in bits (>=2)
DEPTH, 8, number of stack entries (>=2); localparam CNT_W = $clog2(DEPTH+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
op_valid  input  1  opcode/operand offered
op_ready  output  1  core idle, will accept on this edge
op_code  input  4  opcode, sampled on accept
op_arg  input  WIDTH  PUSH operand, sampled on accept
top  output  WIDTH  entry at sp-1; 0 when depth==0
second  output  WIDTH  entry at sp-2; 0 when depth<2
depth  output  CNT_W  current number of entries
out_reg  output  2*WIDTH  output latch
carry  output  1  carry/borrow flag
overflow  output  1  sticky, push beyond DEPTH attempted
underflow  output  1  sticky, too few operands

Behaviour:
- Reset (async, immediate):
  - state=IDLE, op_ready=1, depth=0, out_reg=0, all flags 0.
  - Array contents need not clear; top/second are masked to 0 by depth.
  - Applies mid-operation with no partial commit.
- States:
  - IDLE: op_ready=1. Accept when op_valid && op_ready: latch op_code/op_arg, go to EXEC.
  - EXEC: op_ready=0. Execute. Go to PUSH_HI for MULT when no error, else IDLE.
  - PUSH_HI: push high product half, go to IDLE.
- Latency:
  - Accept at edge N; result visible after edge N+1; op_ready high after N+1.
  - MULT completes at N+2.
  - Max throughput: one op per 2 cycles, MULT one per 3.
- Opcodes (need = operands required; net = depth change):
  - 0 NOOP
  - 1 PUSH: push op_arg. need 0, net +1.
  - 2 POP: need 1, net -1.
  - 3 OUTL: out_reg[WIDTH-1:0]=top, no pop. need 1.
  - 4 OUTH: out_reg[2W-1:W]=top, no pop. need 1.
  - 5 SWAP: need 2.
  - 6 DUP: need 1, net +1.
  - 7 OVER: push second. need 2, net +1.
  - 8 ADD: pop2, push (second+top) mod 2^W; carry=bit W of sum.
  - 9 ADDC: as ADD plus carry-in.
  - A SUB: push second-top; carry=borrow (1 if second<top).
  - B AND, C OR, D XOR: pop2, push result; carry unchanged.
  - E MULT: EXEC replaces top two with low product half; PUSH_HI pushes high half. Final top=high, second=low, net 0.
  - F CLFL: clear carry, overflow, underflow.
- Error checks happen in EXEC before any write:
  - depth<need: underflow=1, stack and carry unchanged, return IDLE.
  - depth+net>DEPTH: overflow=1, stack unchanged.
  - Flags are sticky until CLFL or rst. Errors do not block further ops.
- Arithmetic: unsigned, operands WIDTH bits, product 2*WIDTH bits.
- Boundaries:
  - PUSH at depth==DEPTH-1 succeeds; PUSH at DEPTH overflows.
  - op_valid while op_ready=0 is ignored, not queued; op_code may change freely then.
  - op_valid deasserted in IDLE: hold state indefinitely.

Test Plan:
- WIDTH=8, DEPTH=4: PUSH 0xC8, PUSH 0x64, ADD -> top=0x2C, depth=1, carry=1; then PUSH 0x01, ADDC -> top=0x2E, carry=0.
- PUSH 0x12, PUSH 0x34, MULT -> op_ready low 2 cycles, top=0x03, second=0xA8, depth=2; OUTL, SWAP, OUTH -> out_reg=0xA803.
- PUSH 0x05, PUSH 0x07, SUB -> top=0xFE, carry=1, depth=1.
- Five PUSH (1..5) at DEPTH=4 -> depth=4, top=0x04, overflow=1; CLFL -> overflow=0; after reset, ADD -> underflow=1, depth=0, top=0.
- op_valid held high with PUSH 0xAA for 6 cycles -> exactly 3 accepts, depth=3, op_ready toggles 1/0.
- Assert rst asynchronously during MULT PUSH_HI cycle -> same-cycle depth=0, flags=0, op_ready=1; first op after release executes normally.
